// File: rtl/tl_bank_pkg.sv
// TileLink beat layouts, field widths and opcode constants shared by the bank buffer and its FIFOs.
// The packed beat structs follow the default field widths below.
package tl_bank_pkg;

    localparam int TL_SOURCE_W = 8;
    localparam int TL_ADDR_W   = 33;
    localparam int TL_DATA_W   = 64;
    localparam int TL_MASK_W   = TL_DATA_W / 8;

    localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] TL_A_ARITHMETIC_DATA  = 3'd2;
    localparam logic [2:0] TL_A_LOGICAL_DATA     = 3'd3;
    localparam logic [2:0] TL_A_GET              = 3'd4;
    localparam logic [2:0] TL_A_INTENT           = 3'd5;

    localparam logic [2:0] TL_D_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA  = 3'd1;
    localparam logic [2:0] TL_D_HINT_ACK         = 3'd2;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [2:0]             param;
        logic [2:0]             size;
        logic [TL_SOURCE_W-1:0] source;
        logic [TL_ADDR_W-1:0]   address;
        logic [TL_MASK_W-1:0]   mask;
        logic [TL_DATA_W-1:0]   data;
    } tl_a_beat_t;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [1:0]             param;
        logic [2:0]             size;
        logic [TL_SOURCE_W-1:0] source;
        logic                   denied;
        logic [TL_DATA_W-1:0]   data;
        logic                   corrupt;
    } tl_d_beat_t;

endpackage

// File: rtl/tl_bank_fifo.sv
// Valid/ready FIFO, head read from storage registers; enqueue-to-valid latency one cycle.
// enq_rdy drops when full (even with a simultaneous pop) and while reset is held low.
module tl_bank_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_vld,
    output logic             enq_rdy,
    input  logic [WIDTH-1:0] enq_dat,
    output logic             deq_vld,
    input  logic             deq_rdy,
    output logic [WIDTH-1:0] deq_dat
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push, pop;

    assign enq_rdy = reset & (count_q != FULL_CNT);
    assign deq_vld = (count_q != '0);
    assign deq_dat = mem_q[rd_ptr_q];
    assign push    = enq_vld & enq_rdy;
    assign pop     = deq_vld & deq_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Payload storage carries no reset; only the pointers and occupancy are cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enq_dat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tl_bank_buffer.sv
// TileLink A/D single-beat buffer with outstanding-request limit and sticky size/orphan flags; 1-cycle min latency per channel.
// Backpressure: A stalls when its FIFO is full or inflight hits MAX_INFLIGHT; D stalls when its FIFO is full.
module tl_bank_buffer
    import tl_bank_pkg::*;
#(
    parameter int A_DEPTH      = 4,
    parameter int D_DEPTH      = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int SOURCE_W     = TL_SOURCE_W,
    parameter int ADDR_W       = TL_ADDR_W,
    parameter int DATA_W       = TL_DATA_W
) (
    input  logic                  clock,
    input  logic                  reset,

    output logic                  auto_in_a_ready,
    input  logic                  auto_in_a_valid,
    input  logic [2:0]            auto_in_a_opcode,
    input  logic [2:0]            auto_in_a_param,
    input  logic [2:0]            auto_in_a_size,
    input  logic [SOURCE_W-1:0]   auto_in_a_source,
    input  logic [ADDR_W-1:0]     auto_in_a_address,
    input  logic [DATA_W/8-1:0]   auto_in_a_mask,
    input  logic [DATA_W-1:0]     auto_in_a_data,

    input  logic                  auto_in_d_ready,
    output logic                  auto_in_d_valid,
    output logic [2:0]            auto_in_d_opcode,
    output logic [1:0]            auto_in_d_param,
    output logic [2:0]            auto_in_d_size,
    output logic [SOURCE_W-1:0]   auto_in_d_source,
    output logic                  auto_in_d_denied,
    output logic [DATA_W-1:0]     auto_in_d_data,
    output logic                  auto_in_d_corrupt,

    input  logic                  auto_out_a_ready,
    output logic                  auto_out_a_valid,
    output logic [2:0]            auto_out_a_opcode,
    output logic [2:0]            auto_out_a_param,
    output logic [2:0]            auto_out_a_size,
    output logic [SOURCE_W-1:0]   auto_out_a_source,
    output logic [ADDR_W-1:0]     auto_out_a_address,
    output logic [DATA_W/8-1:0]   auto_out_a_mask,
    output logic [DATA_W-1:0]     auto_out_a_data,

    output logic                  auto_out_d_ready,
    input  logic                  auto_out_d_valid,
    input  logic [2:0]            auto_out_d_opcode,
    input  logic [1:0]            auto_out_d_param,
    input  logic [2:0]            auto_out_d_size,
    input  logic [SOURCE_W-1:0]   auto_out_d_source,
    input  logic                  auto_out_d_sink,
    input  logic                  auto_out_d_denied,
    input  logic [DATA_W-1:0]     auto_out_d_data,
    input  logic                  auto_out_d_corrupt,

    output logic [7:0]            status_inflight,
    output logic                  status_err_size,
    output logic                  status_err_orphan
);

    localparam int         LG_BEAT_BYTES = $clog2(DATA_W / 8);
    localparam logic [7:0] MAX_CNT       = 8'(MAX_INFLIGHT);

    tl_a_beat_t a_enq_dat, a_head;
    tl_d_beat_t d_enq_dat, d_head;
    logic       a_enq_rdy, a_deq_vld;
    logic       d_enq_rdy, d_deq_vld;
    logic       below_limit, a_fire, d_acc, d_fire, size_bad;
    logic [7:0] inflight_q, inflight_d;
    logic       err_size_q, err_size_d;
    logic       err_orphan_q, err_orphan_d;
    logic       unused_sink;

    // The downstream sink id has no upstream counterpart and is dropped.
    assign unused_sink = auto_out_d_sink;

    assign a_enq_dat = '{opcode:  auto_in_a_opcode,
                         param:   auto_in_a_param,
                         size:    auto_in_a_size,
                         source:  auto_in_a_source,
                         address: auto_in_a_address,
                         mask:    auto_in_a_mask,
                         data:    auto_in_a_data};

    assign d_enq_dat = '{opcode:  auto_out_d_opcode,
                         param:   auto_out_d_param,
                         size:    auto_out_d_size,
                         source:  auto_out_d_source,
                         denied:  auto_out_d_denied,
                         data:    auto_out_d_data,
                         corrupt: auto_out_d_corrupt};

    assign below_limit     = (inflight_q < MAX_CNT);
    assign auto_in_a_ready = a_enq_rdy & below_limit;
    assign a_fire          = auto_in_a_valid & auto_in_a_ready;
    assign d_acc           = auto_out_d_valid & auto_out_d_ready;
    assign d_fire          = auto_in_d_valid & auto_in_d_ready;
    assign size_bad        = (int'(auto_in_a_size) > LG_BEAT_BYTES);

    tl_bank_fifo #(
        .WIDTH ($bits(tl_a_beat_t)),
        .DEPTH (A_DEPTH)
    ) u_a_fifo (
        .clock   (clock),
        .reset   (reset),
        .enq_vld (auto_in_a_valid & below_limit),
        .enq_rdy (a_enq_rdy),
        .enq_dat (a_enq_dat),
        .deq_vld (a_deq_vld),
        .deq_rdy (auto_out_a_ready),
        .deq_dat (a_head)
    );

    tl_bank_fifo #(
        .WIDTH ($bits(tl_d_beat_t)),
        .DEPTH (D_DEPTH)
    ) u_d_fifo (
        .clock   (clock),
        .reset   (reset),
        .enq_vld (auto_out_d_valid),
        .enq_rdy (d_enq_rdy),
        .enq_dat (d_enq_dat),
        .deq_vld (d_deq_vld),
        .deq_rdy (auto_in_d_ready),
        .deq_dat (d_head)
    );

    assign auto_out_d_ready   = d_enq_rdy;

    assign auto_out_a_valid   = a_deq_vld;
    assign auto_out_a_opcode  = a_head.opcode;
    assign auto_out_a_param   = a_head.param;
    assign auto_out_a_size    = a_head.size;
    assign auto_out_a_source  = a_head.source;
    assign auto_out_a_address = a_head.address;
    assign auto_out_a_mask    = a_head.mask;
    assign auto_out_a_data    = a_head.data;

    assign auto_in_d_valid    = d_deq_vld;
    assign auto_in_d_opcode   = d_head.opcode;
    assign auto_in_d_param    = d_head.param;
    assign auto_in_d_size     = d_head.size;
    assign auto_in_d_source   = d_head.source;
    assign auto_in_d_denied   = d_head.denied;
    assign auto_in_d_data     = d_head.data;
    assign auto_in_d_corrupt  = d_head.corrupt;

    // A retire with nothing outstanding leaves the count at zero; the orphan flag records it.
    always_comb begin
        inflight_d   = inflight_q;
        err_size_d   = err_size_q | (a_fire & size_bad);
        err_orphan_d = err_orphan_q | (d_acc & (inflight_q == 8'd0));
        case ({a_fire, d_fire})
            2'b10:   inflight_d = inflight_q + 8'd1;
            2'b01:   if (inflight_q != 8'd0) inflight_d = inflight_q - 8'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight_q   <= 8'd0;
            err_size_q   <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            inflight_q   <= inflight_d;
            err_size_q   <= err_size_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign status_inflight   = inflight_q;
    assign status_err_size   = err_size_q;
    assign status_err_orphan = err_orphan_q;

endmodule

// File: tb/tb_tl_bank_buffer.sv
// Bench for tl_bank_buffer: directed vector table, corner sequences, and a queue-based random scoreboard.
module tb_tl_bank_buffer;
    import tl_bank_pkg::*;

    localparam int A_DEPTH = 4;
    localparam int D_DEPTH = 4;
    localparam int MAX_INF = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic       in_a_valid, out_a_ready, out_d_valid, in_d_ready, out_d_sink;
    tl_a_beat_t in_a;
    tl_d_beat_t out_d;

    logic        in_a_ready, out_a_valid, out_d_ready, in_d_valid, err_size, err_orphan;
    logic [7:0]  inflight;
    logic [2:0]  oa_opcode, oa_param, oa_size;
    logic [7:0]  oa_source, oa_mask;
    logic [32:0] oa_address;
    logic [63:0] oa_data;
    logic [2:0]  id_opcode, id_size;
    logic [1:0]  id_param;
    logic [7:0]  id_source;
    logic        id_denied, id_corrupt;
    logic [63:0] id_data;
    tl_a_beat_t  out_a;
    tl_d_beat_t  in_d;

    assign out_a = {oa_opcode, oa_param, oa_size, oa_source, oa_address, oa_mask, oa_data};
    assign in_d  = {id_opcode, id_param, id_size, id_source, id_denied, id_data, id_corrupt};

    logic        r8_in_a_ready, r8_err_size, r8_err_orphan;
    logic [7:0]  r8_inflight;
    logic        unused8_oav, unused8_odr, unused8_idv, unused8_idden, unused8_idcor;
    logic [2:0]  unused8_oaop, unused8_oapar, unused8_oasz, unused8_idop, unused8_idsz;
    logic [1:0]  unused8_idpar;
    logic [7:0]  unused8_oasrc, unused8_oamask, unused8_idsrc;
    logic [32:0] unused8_oaaddr;
    logic [63:0] unused8_oadata, unused8_iddata;

    tl_bank_buffer #(.A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH), .MAX_INFLIGHT(MAX_INF)) u_dut (
        .clock(clock), .reset(reset),
        .auto_in_a_ready(in_a_ready), .auto_in_a_valid(in_a_valid),
        .auto_in_a_opcode(in_a.opcode), .auto_in_a_param(in_a.param), .auto_in_a_size(in_a.size),
        .auto_in_a_source(in_a.source), .auto_in_a_address(in_a.address),
        .auto_in_a_mask(in_a.mask), .auto_in_a_data(in_a.data),
        .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid),
        .auto_in_d_opcode(id_opcode), .auto_in_d_param(id_param), .auto_in_d_size(id_size),
        .auto_in_d_source(id_source), .auto_in_d_denied(id_denied),
        .auto_in_d_data(id_data), .auto_in_d_corrupt(id_corrupt),
        .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
        .auto_out_a_opcode(oa_opcode), .auto_out_a_param(oa_param), .auto_out_a_size(oa_size),
        .auto_out_a_source(oa_source), .auto_out_a_address(oa_address),
        .auto_out_a_mask(oa_mask), .auto_out_a_data(oa_data),
        .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid),
        .auto_out_d_opcode(out_d.opcode), .auto_out_d_param(out_d.param), .auto_out_d_size(out_d.size),
        .auto_out_d_source(out_d.source), .auto_out_d_sink(out_d_sink), .auto_out_d_denied(out_d.denied),
        .auto_out_d_data(out_d.data), .auto_out_d_corrupt(out_d.corrupt),
        .status_inflight(inflight), .status_err_size(err_size), .status_err_orphan(err_orphan)
    );

    // Second build with a deeper inflight limit so the A FIFO becomes the binding constraint.
    tl_bank_buffer #(.A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH), .MAX_INFLIGHT(8)) u_dut8 (
        .clock(clock), .reset(reset),
        .auto_in_a_ready(r8_in_a_ready), .auto_in_a_valid(in_a_valid),
        .auto_in_a_opcode(in_a.opcode), .auto_in_a_param(in_a.param), .auto_in_a_size(in_a.size),
        .auto_in_a_source(in_a.source), .auto_in_a_address(in_a.address),
        .auto_in_a_mask(in_a.mask), .auto_in_a_data(in_a.data),
        .auto_in_d_ready(in_d_ready), .auto_in_d_valid(unused8_idv),
        .auto_in_d_opcode(unused8_idop), .auto_in_d_param(unused8_idpar), .auto_in_d_size(unused8_idsz),
        .auto_in_d_source(unused8_idsrc), .auto_in_d_denied(unused8_idden),
        .auto_in_d_data(unused8_iddata), .auto_in_d_corrupt(unused8_idcor),
        .auto_out_a_ready(out_a_ready), .auto_out_a_valid(unused8_oav),
        .auto_out_a_opcode(unused8_oaop), .auto_out_a_param(unused8_oapar), .auto_out_a_size(unused8_oasz),
        .auto_out_a_source(unused8_oasrc), .auto_out_a_address(unused8_oaaddr),
        .auto_out_a_mask(unused8_oamask), .auto_out_a_data(unused8_oadata),
        .auto_out_d_ready(unused8_odr), .auto_out_d_valid(out_d_valid),
        .auto_out_d_opcode(out_d.opcode), .auto_out_d_param(out_d.param), .auto_out_d_size(out_d.size),
        .auto_out_d_source(out_d.source), .auto_out_d_sink(out_d_sink), .auto_out_d_denied(out_d.denied),
        .auto_out_d_data(out_d.data), .auto_out_d_corrupt(out_d.corrupt),
        .status_inflight(r8_inflight), .status_err_size(r8_err_size), .status_err_orphan(r8_err_orphan)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_a_valid  = 1'b0;
        out_a_ready = 1'b0;
        out_d_valid = 1'b0;
        in_d_ready  = 1'b0;
        out_d_sink  = 1'b0;
        in_a        = '0;
        out_d       = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    function automatic tl_a_beat_t mk_a(input logic [2:0] op, input logic [2:0] par, input logic [2:0] sz,
                                        input logic [7:0] src, input logic [32:0] addr,
                                        input logic [7:0] msk, input logic [63:0] dat);
        tl_a_beat_t b;
        b.opcode = op; b.param = par; b.size = sz; b.source = src;
        b.address = addr; b.mask = msk; b.data = dat;
        return b;
    endfunction

    function automatic tl_a_beat_t rand_a(input logic [2:0] sz);
        return mk_a(3'($urandom_range(0, 5)), 3'($urandom), sz, 8'($urandom),
                    {1'($urandom), 32'($urandom)}, 8'($urandom), {32'($urandom), 32'($urandom)});
    endfunction

    function automatic tl_d_beat_t rand_d(input logic [7:0] src);
        tl_d_beat_t b;
        b.opcode = ($urandom_range(0, 1) != 0) ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
        b.param = 2'($urandom); b.size = 3'($urandom_range(0, 3)); b.source = src;
        b.denied = 1'($urandom); b.data = {32'($urandom), 32'($urandom)}; b.corrupt = 1'($urandom);
        return b;
    endfunction

    typedef struct {
        tl_a_beat_t beat;
        logic       exp_err;
    } vec_t;

    vec_t       vecs[6];
    tl_d_beat_t dresp;
    tl_a_beat_t aq[$];
    tl_d_beat_t dq[$];
    logic [7:0] pend[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        int acc1, acc8, infl;
        logic e_a_rdy, e_oa_vld, e_od_rdy, e_id_vld;
        logic a_f, oa_f, od_f, id_f;

        vecs[0] = '{mk_a(TL_A_GET, 3'd0, 3'd3, 8'h05, 33'h0_8000_0000, 8'hFF, 64'h0), 1'b0};
        vecs[1] = '{mk_a(TL_A_PUT_FULL_DATA, 3'd0, 3'd3, 8'hFF, 33'h1_FFFF_FFF8, 8'hFF, 64'h0123_4567_89AB_CDEF), 1'b0};
        vecs[2] = '{mk_a(TL_A_PUT_PARTIAL_DATA, 3'd0, 3'd0, 8'h00, 33'h0_0000_0000, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF), 1'b0};
        vecs[3] = '{mk_a(TL_A_GET, 3'd0, 3'd4, 8'h11, 33'h0_1234_5670, 8'hFF, 64'h0), 1'b1};
        vecs[4] = '{mk_a(TL_A_LOGICAL_DATA, 3'd7, 3'd2, 8'hA5, 33'h1_5555_AAAC, 8'hF0, 64'hDEAD_BEEF_CAFE_F00D), 1'b1};
        vecs[5] = '{mk_a(TL_A_INTENT, 3'd1, 3'd7, 8'h5A, 33'h0_AAAA_5550, 8'h0F, 64'h8000_0000_0000_0001), 1'b1};

        idle();
        #2 reset = 1'b0;
        @(negedge clock);
        check("rst_in_a_ready", 128'(in_a_ready), 128'(0));
        check("rst_out_d_ready", 128'(out_d_ready), 128'(0));
        check("rst_out_a_valid", 128'(out_a_valid), 128'(0));
        check("rst_in_d_valid", 128'(in_d_valid), 128'(0));
        check("rst_inflight", 128'(inflight), 128'(0));
        check("rst_errs", 128'({err_size, err_orphan}), 128'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("post_rst_in_a_ready", 128'(in_a_ready), 128'(1));
        check("post_rst_out_d_ready", 128'(out_d_ready), 128'(1));
        tick();

        // Directed vectors: each beat travels down, a response comes back, and the count returns to zero.
        for (int i = 0; i < 6; i++) begin
            in_a = vecs[i].beat; in_a_valid = 1'b1; out_a_ready = 1'b1;
            @(negedge clock);
            check("vec_in_a_ready", 128'(in_a_ready), 128'(1));
            check("vec_no_comb_path", 128'(out_a_valid), 128'(0));
            tick(); in_a_valid = 1'b0;
            @(negedge clock);
            check("vec_out_a_valid", 128'(out_a_valid), 128'(1));
            check("vec_out_a_fields", 128'(out_a), 128'(vecs[i].beat));
            check("vec_inflight_1", 128'(inflight), 128'(1));
            tick();
            @(negedge clock);
            check("vec_out_a_drained", 128'(out_a_valid), 128'(0));
            check("vec_err_size", 128'(err_size), 128'(vecs[i].exp_err));
            dresp = '{opcode: TL_D_ACCESS_ACK_DATA, param: 2'(i), size: vecs[i].beat.size,
                      source: vecs[i].beat.source, denied: 1'(i), data: ~vecs[i].beat.data,
                      corrupt: 1'(i >> 1)};
            out_d = dresp; out_d_valid = 1'b1; out_d_sink = 1'b1; in_d_ready = 1'b0;
            tick(); out_d_valid = 1'b0;
            @(negedge clock);
            check("vec_in_d_valid", 128'(in_d_valid), 128'(1));
            check("vec_in_d_fields", 128'(in_d), 128'(dresp));
            tick();
            @(negedge clock);
            check("vec_in_d_held", 128'(in_d), 128'(dresp));
            check("vec_inflight_held", 128'(inflight), 128'(1));
            in_d_ready = 1'b1;
            tick(); in_d_ready = 1'b0;
            @(negedge clock);
            check("vec_inflight_0", 128'(inflight), 128'(0));
            check("vec_in_d_drained", 128'(in_d_valid), 128'(0));
            tick();
        end

        // Orphan response: forwarded, flagged, count stays at zero.
        check("orphan_flag_before", 128'(err_orphan), 128'(0));
        dresp = '{opcode: TL_D_ACCESS_ACK, param: 2'd3, size: 3'd2, source: 8'h77,
                  denied: 1'b1, data: 64'h1111_2222_3333_4444, corrupt: 1'b0};
        out_d = dresp; out_d_valid = 1'b1; out_d_sink = 1'b1;
        tick(); out_d_valid = 1'b0;
        @(negedge clock);
        check("orphan_flag", 128'(err_orphan), 128'(1));
        check("orphan_forwarded", 128'(in_d), 128'(dresp));
        in_d_ready = 1'b1;
        tick(); in_d_ready = 1'b0;
        @(negedge clock);
        check("orphan_inflight", 128'(inflight), 128'(0));
        check("orphan_sticky", 128'(err_orphan), 128'(1));
        check("size_sticky", 128'(err_size), 128'(1));
        tick();

        // Accept and retire in the same cycle at inflight=2.
        out_a_ready = 1'b1; in_a = rand_a(3'd3); in_a_valid = 1'b1;
        tick(); in_a = rand_a(3'd1);
        tick(); in_a_valid = 1'b0;
        tick(); out_d = rand_d(8'h01); out_d_valid = 1'b1;
        tick(); out_d_valid = 1'b0;
        @(negedge clock);
        check("simul_pre_inflight", 128'(inflight), 128'(2));
        in_a = rand_a(3'd2); in_a_valid = 1'b1; in_d_ready = 1'b1;
        #1;
        check("simul_in_a_ready", 128'(in_a_ready), 128'(1));
        tick(); in_a_valid = 1'b0; in_d_ready = 1'b0;
        @(negedge clock);
        check("simul_inflight", 128'(inflight), 128'(2));

        // Inflight limit (MAX=3) versus FIFO-full limit (MAX=8 build), with illegal-size beats.
        do_reset();
        in_a = mk_a(TL_A_GET, 3'd0, 3'd5, 8'h42, 33'h0_0000_1000, 8'hFF, 64'h0);
        in_a_valid = 1'b1;
        acc1 = 0; acc8 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            acc1 += int'(in_a_ready);
            acc8 += int'(r8_in_a_ready);
            tick();
        end
        in_a_valid = 1'b0;
        @(negedge clock);
        check("limit_accepts", 128'(acc1), 128'(3));
        check("limit_in_a_ready", 128'(in_a_ready), 128'(0));
        check("limit_inflight", 128'(inflight), 128'(3));
        check("full_accepts_m8", 128'(acc8), 128'(4));
        check("full_in_a_ready_m8", 128'(r8_in_a_ready), 128'(0));
        check("full_inflight_m8", 128'(r8_inflight), 128'(4));
        check("bad_size_flag", 128'(err_size), 128'(1));
        check("bad_size_forwarded", 128'(out_a), 128'(in_a));

        // Mid-operation reset with three beats queued.
        #1 reset = 1'b0;
        #1;
        check("midrst_out_a_valid", 128'(out_a_valid), 128'(0));
        check("midrst_readies", 128'({in_a_ready, out_d_ready}), 128'(0));
        check("midrst_inflight", 128'(inflight), 128'(0));
        check("midrst_err_size", 128'(err_size), 128'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("postrst_out_a_valid", 128'(out_a_valid), 128'(0));
        check("postrst_in_d_valid", 128'(in_d_valid), 128'(0));
        check("postrst_status", 128'({inflight, err_size, err_orphan}), 128'(0));
        check("postrst_in_a_ready", 128'(in_a_ready), 128'(1));
        tick();

        // Random traffic against a queue-level reference.
        do_reset();
        infl = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_a        = rand_a(3'($urandom_range(0, 3)));
            in_a_valid  = ($urandom_range(0, 3) != 0);
            out_a_ready = ($urandom_range(0, 2) != 0);
            in_d_ready  = ($urandom_range(0, 2) != 0);
            out_d_sink  = 1'($urandom);
            out_d_valid = 1'b0;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                out_d = rand_d(pend[0]);
                out_d_valid = 1'b1;
            end
            @(negedge clock);
            e_a_rdy  = (aq.size() < A_DEPTH) && (infl < MAX_INF);
            e_oa_vld = (aq.size() > 0);
            e_od_rdy = (dq.size() < D_DEPTH);
            e_id_vld = (dq.size() > 0);
            check("rnd_in_a_ready", 128'(in_a_ready), 128'(e_a_rdy));
            check("rnd_out_a_valid", 128'(out_a_valid), 128'(e_oa_vld));
            if (e_oa_vld) check("rnd_out_a_head", 128'(out_a), 128'(aq[0]));
            check("rnd_out_d_ready", 128'(out_d_ready), 128'(e_od_rdy));
            check("rnd_in_d_valid", 128'(in_d_valid), 128'(e_id_vld));
            if (e_id_vld) check("rnd_in_d_head", 128'(in_d), 128'(dq[0]));
            check("rnd_inflight", 128'(inflight), 128'(infl));
            a_f  = in_a_valid & e_a_rdy;
            oa_f = e_oa_vld & out_a_ready;
            od_f = out_d_valid & e_od_rdy;
            id_f = e_id_vld & in_d_ready;
            if (oa_f) begin
                pend.push_back(aq[0].source);
                void'(aq.pop_front());
            end
            if (a_f) aq.push_back(in_a);
            if (od_f) begin
                void'(pend.pop_front());
                dq.push_back(out_d);
            end
            if (id_f) void'(dq.pop_front());
            if (a_f && !id_f) infl++;
            else if (id_f && !a_f && infl > 0) infl--;
            tick();
        end
        idle();
        @(negedge clock);
        check("rnd_no_errs", 128'({err_size, err_orphan}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
